// File: rtl/emscripten_dom_vk_pkg.sv
// ---------------------------------------------------------------------------
// emscripten_dom_vk_pkg
// Shared definitions for the DOM key-name to virtual-key-code converter:
//   - state_t        : controller states
//   - VK_PREFIX      : the mandatory "DOM_VK_" name prefix
//   - DOM_VK_*       : virtual key codes held in the named-key table
//   - ROM_DEPTH      : number of named-key table entries
//   - MAX_NAME_LEN   : longest suffix (after the prefix) that is buffered
//   - small ASCII helpers used by the digit / letter classification
// ---------------------------------------------------------------------------
package emscripten_dom_vk_pkg;

  localparam int ROM_DEPTH    = 16;
  localparam int MAX_NAME_LEN = 16;
  localparam int PREFIX_LEN   = 7;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREFIX   = 3'd1,
    SUFFIX   = 3'd2,
    DRAIN    = 3'd3,
    CLASSIFY = 3'd4,
    SCAN     = 3'd5,
    DONE     = 3'd6
  } state_t;

  // Suffix bytes, element 0 is the first character after the prefix.
  typedef logic [MAX_NAME_LEN-1:0][7:0] name_t;

  localparam logic [8*PREFIX_LEN-1:0] VK_PREFIX  = "DOM_VK_";
  localparam logic [47:0]             NUMPAD_STR = "NUMPAD";

  localparam logic [31:0] DOM_VK_RETURN     = 32'h0000_000D;
  localparam logic [31:0] DOM_VK_ESCAPE     = 32'h0000_001B;
  localparam logic [31:0] DOM_VK_SPACE      = 32'h0000_0020;
  localparam logic [31:0] DOM_VK_TAB        = 32'h0000_0009;
  localparam logic [31:0] DOM_VK_BACK_SPACE = 32'h0000_0008;
  localparam logic [31:0] DOM_VK_SHIFT      = 32'h0000_0010;
  localparam logic [31:0] DOM_VK_CONTROL    = 32'h0000_0011;
  localparam logic [31:0] DOM_VK_ALT        = 32'h0000_0012;
  localparam logic [31:0] DOM_VK_LEFT       = 32'h0000_0025;
  localparam logic [31:0] DOM_VK_UP         = 32'h0000_0026;
  localparam logic [31:0] DOM_VK_RIGHT      = 32'h0000_0027;
  localparam logic [31:0] DOM_VK_DOWN       = 32'h0000_0028;
  localparam logic [31:0] DOM_VK_INSERT     = 32'h0000_002D;
  localparam logic [31:0] DOM_VK_DELETE     = 32'h0000_002E;
  localparam logic [31:0] DOM_VK_HOME       = 32'h0000_0024;
  localparam logic [31:0] DOM_VK_END        = 32'h0000_0023;

  // Expected prefix character at position idx (0..6).
  function automatic logic [7:0] prefix_char(input logic [2:0] idx);
    case (idx)
      3'd0:    prefix_char = "D";
      3'd1:    prefix_char = "O";
      3'd2:    prefix_char = "M";
      3'd3:    prefix_char = "_";
      3'd4:    prefix_char = "V";
      3'd5:    prefix_char = "K";
      3'd6:    prefix_char = "_";
      default: prefix_char = 8'h00;
    endcase
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    is_digit = (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic is_upper(input logic [7:0] b);
    is_upper = (b >= 8'h41) && (b <= 8'h5A);
  endfunction

endpackage

// File: rtl/emscripten_dom_vk_name_rom.sv
// ---------------------------------------------------------------------------
// emscripten_dom_vk_name_rom
// Combinational table of named DOM keys (suffix after "DOM_VK_").
//   index : entry select, 0..15
//   name  : suffix bytes, name[0] is the first character, zero padded
//   len   : number of valid bytes in name
//   code  : DOM virtual key code of the entry
// ---------------------------------------------------------------------------
module emscripten_dom_vk_name_rom
  import emscripten_dom_vk_pkg::*;
(
  input  logic [3:0]  index,
  output name_t       name,
  output logic [4:0]  len,
  output logic [31:0] code
);

  // Names are stored left-aligned: the first character sits in the top byte
  // and the tail is zero padded to the full buffer width.
  logic [8*MAX_NAME_LEN-1:0] text;

  always_comb begin
    text = '0;
    len  = '0;
    code = '0;
    case (index)
      4'd0:  begin text = {"RETURN",     80'd0};  len = 5'd6;  code = DOM_VK_RETURN;     end
      4'd1:  begin text = {"ESCAPE",     80'd0};  len = 5'd6;  code = DOM_VK_ESCAPE;     end
      4'd2:  begin text = {"SPACE",      88'd0};  len = 5'd5;  code = DOM_VK_SPACE;      end
      4'd3:  begin text = {"TAB",        104'd0}; len = 5'd3;  code = DOM_VK_TAB;        end
      4'd4:  begin text = {"BACK_SPACE", 48'd0};  len = 5'd10; code = DOM_VK_BACK_SPACE; end
      4'd5:  begin text = {"SHIFT",      88'd0};  len = 5'd5;  code = DOM_VK_SHIFT;      end
      4'd6:  begin text = {"CONTROL",    72'd0};  len = 5'd7;  code = DOM_VK_CONTROL;    end
      4'd7:  begin text = {"ALT",        104'd0}; len = 5'd3;  code = DOM_VK_ALT;        end
      4'd8:  begin text = {"LEFT",       96'd0};  len = 5'd4;  code = DOM_VK_LEFT;       end
      4'd9:  begin text = {"UP",         112'd0}; len = 5'd2;  code = DOM_VK_UP;         end
      4'd10: begin text = {"RIGHT",      88'd0};  len = 5'd5;  code = DOM_VK_RIGHT;      end
      4'd11: begin text = {"DOWN",       96'd0};  len = 5'd4;  code = DOM_VK_DOWN;       end
      4'd12: begin text = {"INSERT",     80'd0};  len = 5'd6;  code = DOM_VK_INSERT;     end
      4'd13: begin text = {"DELETE",     80'd0};  len = 5'd6;  code = DOM_VK_DELETE;     end
      4'd14: begin text = {"HOME",       96'd0};  len = 5'd4;  code = DOM_VK_HOME;       end
      4'd15: begin text = {"END",        104'd0}; len = 5'd3;  code = DOM_VK_END;        end
      default: begin text = '0; len = '0; code = '0; end
    endcase
  end

  // Unpack left-aligned text into per-character bytes.
  generate
    for (genvar gi = 0; gi < MAX_NAME_LEN; gi++) begin : g_unpack
      assign name[gi] = text[8*(MAX_NAME_LEN-gi)-1 -: 8];
    end
  endgenerate

endmodule

// File: rtl/emscripten_dom_string_to_vk.sv
// ---------------------------------------------------------------------------
// emscripten_dom_string_to_vk
// Converts a NUL-terminated "DOM_VK_<name>" string, streamed one byte per
// handshake, into its DOM virtual key code (0 when unknown or malformed).
//   clock, resetn  : clock and asynchronous active-low reset
//   start / busy   : call request / call in progress
//   char_valid, char_data, char_ready : name byte stream, 0x00 terminates
//   done / stall   : result valid / consumer not ready
//   returndata     : resulting key code, held while done && stall
// Flow: IDLE -> PREFIX -> SUFFIX (or DRAIN) -> CLASSIFY -> [SCAN] -> DONE.
// ---------------------------------------------------------------------------
module emscripten_dom_string_to_vk
  import emscripten_dom_vk_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        done,
  input  logic        stall,
  output logic [31:0] returndata
);

  state_t      state_reg;
  logic [2:0]  prefix_idx_reg;
  logic [4:0]  len_reg;
  logic        invalid_reg;
  logic [3:0]  scan_idx_reg;
  name_t       sfx_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        char_ready_reg;
  logic [31:0] result_reg;

  // ------------------------------------------------------------------
  // Named-key table lookup, one entry per SCAN cycle
  // ------------------------------------------------------------------
  name_t       rom_name;
  logic [4:0]  rom_len;
  logic [31:0] rom_code;

  emscripten_dom_vk_name_rom u_rom (
    .index (scan_idx_reg),
    .name  (rom_name),
    .len   (rom_len),
    .code  (rom_code)
  );

  // Bytes past the stored length are stale from earlier calls, so they are
  // masked out of the compare rather than cleared at every start.
  logic [MAX_NAME_LEN-1:0] rom_byte_ok;
  generate
    for (genvar gi = 0; gi < MAX_NAME_LEN; gi++) begin : g_rom_cmp
      assign rom_byte_ok[gi] = (5'(gi) >= len_reg) || (sfx_reg[gi] == rom_name[gi]);
    end
  endgenerate

  logic rom_hit;
  assign rom_hit = (rom_len == len_reg) && (&rom_byte_ok);

  // ------------------------------------------------------------------
  // Direct (non-table) name classes
  // ------------------------------------------------------------------
  logic [5:0] numpad_eq;
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_numpad_cmp
      assign numpad_eq[gi] = (sfx_reg[gi] == NUMPAD_STR[47-8*gi -: 8]);
    end
  endgenerate

  logic numpad_ok;
  assign numpad_ok = (len_reg == 5'd7) && (&numpad_eq) && is_digit(sfx_reg[6]);

  // F1..F9: one digit, not zero. F10..F24: leading '1' or '2', value <= 24.
  logic       f_one_ok;
  logic       f_two_ok;
  logic [7:0] f_two_val;

  assign f_two_val = (8'd10 * {4'd0, sfx_reg[1][3:0]}) + {4'd0, sfx_reg[2][3:0]};
  assign f_one_ok  = (len_reg == 5'd2) && (sfx_reg[0] == "F") &&
                     (sfx_reg[1] >= "1") && (sfx_reg[1] <= "9");
  assign f_two_ok  = (len_reg == 5'd3) && (sfx_reg[0] == "F") &&
                     ((sfx_reg[1] == "1") || (sfx_reg[1] == "2")) &&
                     is_digit(sfx_reg[2]) && (f_two_val <= 8'd24);

  logic        direct_hit;
  logic [31:0] direct_code;

  always_comb begin
    direct_hit  = 1'b0;
    direct_code = '0;
    if (invalid_reg || (len_reg == 5'd0)) begin
      direct_hit = 1'b1;
    end else if ((len_reg == 5'd1) && (is_upper(sfx_reg[0]) || is_digit(sfx_reg[0]))) begin
      direct_hit  = 1'b1;
      direct_code = {24'd0, sfx_reg[0]};
    end else if (f_one_ok) begin
      direct_hit  = 1'b1;
      direct_code = {24'd0, 8'h6F + {4'd0, sfx_reg[1][3:0]}};
    end else if (f_two_ok) begin
      direct_hit  = 1'b1;
      direct_code = {24'd0, 8'h6F + f_two_val};
    end else if (numpad_ok) begin
      direct_hit  = 1'b1;
      direct_code = {24'd0, 8'h60 + {4'd0, sfx_reg[6][3:0]}};
    end
  end

  // ------------------------------------------------------------------
  // Controller
  // ------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      prefix_idx_reg <= '0;
      len_reg        <= '0;
      invalid_reg    <= 1'b0;
      scan_idx_reg   <= '0;
      sfx_reg        <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      char_ready_reg <= 1'b0;
      result_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg      <= PREFIX;
            prefix_idx_reg <= '0;
            len_reg        <= '0;
            invalid_reg    <= 1'b0;
            busy_reg       <= 1'b1;
            char_ready_reg <= 1'b1;
          end
        end

        PREFIX: begin
          if (char_valid) begin
            if (char_data == 8'h00) begin
              state_reg      <= CLASSIFY;
              invalid_reg    <= 1'b1;
              char_ready_reg <= 1'b0;
            end else if (char_data != prefix_char(prefix_idx_reg)) begin
              state_reg <= DRAIN;
            end else if (prefix_idx_reg == 3'(PREFIX_LEN-1)) begin
              state_reg <= SUFFIX;
              len_reg   <= '0;
            end else begin
              prefix_idx_reg <= prefix_idx_reg + 3'd1;
            end
          end
        end

        SUFFIX: begin
          if (char_valid) begin
            if (char_data == 8'h00) begin
              state_reg      <= CLASSIFY;
              char_ready_reg <= 1'b0;
            end else if (len_reg == 5'(MAX_NAME_LEN)) begin
              // Too long for any known name: swallow the rest.
              state_reg <= DRAIN;
            end else begin
              sfx_reg[len_reg[3:0]] <= char_data;
              len_reg               <= len_reg + 5'd1;
            end
          end
        end

        DRAIN: begin
          if (char_valid && (char_data == 8'h00)) begin
            state_reg      <= CLASSIFY;
            invalid_reg    <= 1'b1;
            char_ready_reg <= 1'b0;
          end
        end

        CLASSIFY: begin
          if (direct_hit) begin
            state_reg  <= DONE;
            result_reg <= direct_code;
            done_reg   <= 1'b1;
          end else begin
            state_reg    <= SCAN;
            scan_idx_reg <= '0;
          end
        end

        SCAN: begin
          if (rom_hit) begin
            state_reg  <= DONE;
            result_reg <= rom_code;
            done_reg   <= 1'b1;
          end else if (scan_idx_reg == 4'(ROM_DEPTH-1)) begin
            state_reg  <= DONE;
            result_reg <= '0;
            done_reg   <= 1'b1;
          end else begin
            scan_idx_reg <= scan_idx_reg + 4'd1;
          end
        end

        DONE: begin
          if (!stall) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
          end
        end

        default: begin
          state_reg      <= IDLE;
          busy_reg       <= 1'b0;
          done_reg       <= 1'b0;
          char_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign char_ready = char_ready_reg;
  assign returndata = result_reg;

endmodule

// File: tb/tb_emscripten_dom_string_to_vk.sv
// ---------------------------------------------------------------------------
// tb_emscripten_dom_string_to_vk
// Directed calls from the test plan followed by randomized names, each
// checked against a string-level reference model of the naming rules.
// Latency is counted in clock edges after the edge that accepts the NUL.
// ---------------------------------------------------------------------------
module tb_emscripten_dom_string_to_vk;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic        busy;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        done;
  logic        stall;
  logic [31:0] returndata;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  emscripten_dom_string_to_vk dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .busy       (busy),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .done       (done),
    .stall      (stall),
    .returndata (returndata)
  );

  string       rom_names [16] = '{"RETURN", "ESCAPE", "SPACE", "TAB", "BACK_SPACE",
                                  "SHIFT", "CONTROL", "ALT", "LEFT", "UP", "RIGHT",
                                  "DOWN", "INSERT", "DELETE", "HOME", "END"};
  logic [31:0] rom_codes [16] = '{32'h0D, 32'h1B, 32'h20, 32'h09, 32'h08, 32'h10,
                                  32'h11, 32'h12, 32'h25, 32'h26, 32'h27, 32'h28,
                                  32'h2D, 32'h2E, 32'h24, 32'h23};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_dig(input byte c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic bit is_up(input byte c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  // Reference: code and edges-after-NUL until done is visible.
  function automatic void ref_model(input string s, output logic [31:0] code, output int lat);
    string suf;
    byte   c;
    int    n;
    bit    ok;
    code = '0;
    lat  = 1;
    if (s.len() <= 7) return;
    if (s.substr(0, 6) != "DOM_VK_") return;
    suf = s.substr(7, s.len() - 1);
    if (suf.len() > 16) return;
    if (suf.len() == 1) begin
      c = suf.getc(0);
      if (is_up(c) || is_dig(c)) begin
        code = {24'd0, c};
        return;
      end
    end
    if ((suf.getc(0) == 8'h46) && (suf.len() == 2 || suf.len() == 3)) begin
      ok = (suf.getc(1) != 8'h30);
      n  = 0;
      for (int i = 1; i < suf.len(); i++) begin
        c = suf.getc(i);
        if (!is_dig(c)) ok = 0;
        else n = n * 10 + (c - 48);
      end
      if (ok && n >= 1 && n <= 24) begin
        code = 32'h6F + 32'(n);
        return;
      end
    end
    if (suf.len() == 7 && suf.substr(0, 5) == "NUMPAD" && is_dig(suf.getc(6))) begin
      code = 32'h60 + 32'(suf.getc(6) - 48);
      return;
    end
    for (int i = 0; i < 16; i++) begin
      if (suf == rom_names[i]) begin
        code = rom_codes[i];
        lat  = 2 + i;
        return;
      end
    end
    lat = 17;
  endfunction

  // One full call: start, stream name + NUL with random gaps, wait for done,
  // hold stall for 'hold' cycles (optionally poking start), then consume.
  task automatic do_call(input string s, input logic [31:0] exp_code, input int exp_lat,
                         input int gap, input int hold, input bit poke_start);
    byte         b[$];
    int          idx;
    int          guard;
    int          lat;
    bit          fire;
    logic [31:0] held;
    for (int i = 0; i < s.len(); i++) b.push_back(s.getc(i));
    b.push_back(8'h00);
    stall = 1'b1;
    idx   = 0;
    guard = 0;
    @(negedge clock);
    start = 1'b1;
    while (idx < b.size() && guard < 400) begin
      char_valid = ($urandom_range(0, 99) >= gap);
      char_data  = b[idx];
      fire       = char_valid && char_ready;
      @(posedge clock);
      if (fire) idx++;
      @(negedge clock);
      if (guard == 0) begin
        start = 1'b0;
        check($sformatf("%s busy after start", s), {31'd0, busy}, 32'd1);
      end
      guard++;
    end
    check($sformatf("%s bytes consumed", s), 32'(idx), 32'(b.size()));
    check($sformatf("%s char_ready after NUL", s), {31'd0, char_ready}, 32'd0);
    char_valid = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check($sformatf("%s done", s), {31'd0, done}, 32'd1);
    check($sformatf("%s returndata", s), returndata, exp_code);
    check($sformatf("%s latency", s), 32'(lat), 32'(exp_lat));
    held = returndata;
    for (int j = 0; j < hold; j++) begin
      if (poke_start && j == 0) start = 1'b1;
      @(negedge clock);
      check($sformatf("%s stalled done", s), {31'd0, done}, 32'd1);
      check($sformatf("%s stalled returndata", s), returndata, held);
    end
    start = 1'b0;
    stall = 1'b0;
    @(negedge clock);
    check($sformatf("%s done after consume", s), {31'd0, done}, 32'd0);
    check($sformatf("%s busy after consume", s), {31'd0, busy}, 32'd0);
    if (poke_start) begin
      @(negedge clock);
      check($sformatf("%s start ignored", s), {31'd0, busy}, 32'd0);
    end
    $display("call %s -> %08h latency %0d", s, held, lat);
  endtask

  task automatic rand_call();
    string       s;
    logic [31:0] code;
    int          lat;
    int          cat;
    int          n;
    byte         c;
    cat = $urandom_range(0, 9);
    s   = "DOM_VK_";
    case (cat)
      0: s = {s, rom_names[$urandom_range(0, 15)]};
      1: s = $sformatf("%s%c", s, 8'(8'h41 + $urandom_range(0, 25)));
      2: s = $sformatf("%s%c", s, 8'(8'h30 + $urandom_range(0, 9)));
      3: s = $sformatf("%sF%0d", s, $urandom_range(0, 30));
      4: s = $sformatf("%sNUMPAD%c", s, 8'(8'h2F + $urandom_range(0, 12)));
      5: begin
        n = $urandom_range(1, 20);
        for (int i = 0; i < n; i++) begin
          c = 8'($urandom_range(0, 36));
          if (c < 26) c = 8'h41 + c;
          else if (c < 36) c = 8'h30 + (c - 26);
          else c = 8'h5F;
          s = $sformatf("%s%c", s, c);
        end
      end
      6: begin
        s = {s, rom_names[$urandom_range(0, 15)]};
        s.putc($urandom_range(0, 6), 8'h51);
      end
      7: s = s.substr(0, $urandom_range(0, 5));
      8: s = $sformatf("%s%c", s, 8'(8'h61 + $urandom_range(0, 25)));
      default: begin
        s = {s, rom_names[$urandom_range(0, 15)]};
        s = s.substr(0, s.len() - 2);
      end
    endcase
    ref_model(s, code, lat);
    do_call(s, code, lat, $urandom_range(0, 40), $urandom_range(0, 3), 1'b0);
  endtask

  initial begin
    string s;
    int    accepted;
    int    guard;
    bit    fire;

    resetn     = 1'b0;
    start      = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;
    stall      = 1'b0;
    repeat (3) @(negedge clock);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset char_ready", {31'd0, char_ready}, 32'd0);
    check("reset returndata", returndata, 32'd0);
    resetn = 1'b1;

    // Directed calls
    do_call("DOM_VK_Q",       32'h51, 1,  0, 0, 1'b0);
    do_call("DOM_VK_F12",     32'h7B, 1,  0, 1, 1'b0);
    do_call("DOM_VK_F1",      32'h70, 1,  0, 0, 1'b0);
    do_call("DOM_VK_F24",     32'h87, 1, 20, 0, 1'b0);
    do_call("DOM_VK_F25",     32'h00, 17, 0, 0, 1'b0);
    do_call("DOM_VK_F0",      32'h00, 17, 0, 0, 1'b0);
    do_call("DOM_VK_NUMPAD7", 32'h67, 1,  0, 0, 1'b0);
    do_call("DOM_VK_END",     32'h23, 17, 0, 0, 1'b0);
    do_call("DOM_VK_RETURN",  32'h0D, 2,  0, 0, 1'b0);
    do_call("DOM_XK_A",       32'h00, 1,  0, 0, 1'b0);
    do_call("DOM_VK_",        32'h00, 1,  0, 0, 1'b0);
    do_call("DOM_VK_ABCDEFGHIJKLMNOPQRST", 32'h00, 1, 0, 0, 1'b0);
    do_call("DOM_VK_a",       32'h00, 17, 0, 0, 1'b0);
    do_call("DOM_VK_SPACE",   32'h20, 4,  0, 5, 1'b1);

    // Reset in the middle of the suffix with char_valid held high
    s        = "DOM_VK_AB";
    accepted = 0;
    guard    = 0;
    @(negedge clock);
    start      = 1'b1;
    char_valid = 1'b1;
    char_data  = s.getc(0);
    while (accepted < s.len() && guard < 50) begin
      fire = char_ready;
      @(posedge clock);
      if (fire) accepted++;
      @(negedge clock);
      start = 1'b0;
      if (accepted < s.len()) char_data = s.getc(accepted);
      guard++;
    end
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("async reset busy", {31'd0, busy}, 32'd0);
    check("async reset char_ready", {31'd0, char_ready}, 32'd0);
    check("async reset done", {31'd0, done}, 32'd0);
    check("async reset returndata", returndata, 32'd0);
    @(negedge clock);
    char_valid = 1'b0;
    resetn     = 1'b1;
    do_call("DOM_VK_TAB", 32'h09, 5, 0, 0, 1'b0);

    // Randomized names against the reference model
    for (int t = 0; t < 60; t++) rand_call();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
